// File: rtl/pc_redirect_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit_pkg
//   Shared definitions for the fetch-PC redirect logic: EX-stage branch op
//   encodings, the redirect FSM state type and a small op-class helper.
// -----------------------------------------------------------------------------
package pc_redirect_unit_pkg;

    // EX-stage branch op encodings. Bit 3 marks the branch/jump class.
    localparam logic [3:0] BR_BEQ      = 4'b1000;
    localparam logic [3:0] BR_BNE      = 4'b1001;
    localparam logic [3:0] BR_JAL_JALR = 4'b1010;
    localparam logic [3:0] BR_BLT      = 4'b1100;
    localparam logic [3:0] BR_BGE      = 4'b1101;
    localparam logic [3:0] BR_BLTU     = 4'b1110;
    localparam logic [3:0] BR_BGEU     = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

    // True for any op in the branch/jump class. Bit 3 alone defines the class,
    // so the unassigned 4'b1011 is treated as a branch op as well.
    function automatic logic is_branch_op(input logic [3:0] op);
        logic r;
        case (op)
            BR_BEQ, BR_BNE, BR_JAL_JALR, BR_BLT,
            BR_BGE, BR_BLTU, BR_BGEU, 4'b1011: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//   Owns the architectural fetch PC. Advances by 4, holds on stall or while
//   instruction memory is busy, and redirects on a taken EX-stage branch/jump.
//   A redirect that arrives while memory is busy is parked in pend_addr and
//   applied on the first edge the memory is free. Misaligned targets are
//   replaced by TRAP_VECTOR and reported through misalign_exc/bad_addr.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   ex_valid      in   EX instruction is real (0 = bubble)
//   branch_op     in   EX branch op, bit 3 = branch/jump class
//   branch_taken  in   branch condition result for the EX instruction
//   target_addr   in   branch/jump destination from the EX ALU
//   stall         in   hazard-unit request to hold IF
//   imem_busy     in   instruction memory mid-access, fetch address frozen
//   pc            out  current fetch address (registered)
//   pc_plus4      out  pc + 4, wraps mod 2^32 (combinational)
//   flush_ifid    out  kill IF/ID contents at next edge (combinational)
//   flush_idex    out  kill ID/EX contents at next edge (combinational)
//   redirect      out  registered pulse: pc took a non-sequential value
//   misalign_exc  out  registered pulse: a misaligned target was trapped
//   bad_addr      out  last misaligned target, held until the next trap
//   dbg_state     out  redirect FSM state
//
// Qualifier semantics: ex_valid qualifies the whole EX bundle (branch_op,
// branch_taken, target_addr) in the cycle it is high; there is no back
// pressure toward EX, a taken branch is always accepted in that same cycle.
// -----------------------------------------------------------------------------
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [3:0]  branch_op,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    input  logic        stall,
    input  logic        imem_busy,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        redirect,
    output logic        misalign_exc,
    output logic [31:0] bad_addr,
    output pc_state_e   dbg_state
);

    pc_state_e   state, state_next;
    logic [31:0] pend_addr, pend_next;
    logic [31:0] pc_next;
    logic        redirect_next;
    logic        take;
    logic        misalign;
    logic [31:0] dest;
    logic [31:0] pend_eff;

    assign take     = ex_valid & is_branch_op(branch_op) & branch_taken;
    assign misalign = take & (target_addr[1:0] != 2'b00);
    assign dest     = misalign ? TRAP_VECTOR : target_addr;
    assign pc_plus4 = pc + 32'd4;

    // Gated by reset_n so no flush escapes while the unit is held in reset.
    assign flush_ifid = reset_n & (take | (state == ST_PEND));
    assign flush_idex = reset_n & take;

    assign dbg_state = state;

    // A new take while parked overwrites the parked target (last wins).
    assign pend_eff = take ? dest : pend_addr;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pend_next     = pend_addr;
        redirect_next = 1'b0;
        case (state)
            ST_RUN: begin
                if (take) begin
                    if (!imem_busy) begin
                        pc_next       = dest;
                        redirect_next = 1'b1;
                    end else begin
                        pend_next  = dest;
                        state_next = ST_PEND;
                    end
                end else if (!(stall | imem_busy)) begin
                    pc_next = pc_plus4;
                end
            end
            ST_PEND: begin
                // Draining outranks stall: the stalled ID slot is flushed.
                if (!imem_busy) begin
                    pc_next       = pend_eff;
                    redirect_next = 1'b1;
                    state_next    = ST_RUN;
                end else begin
                    pend_next = pend_eff;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RUN;
            pc           <= RESET_VECTOR;
            pend_addr    <= 32'h0;
            redirect     <= 1'b0;
            misalign_exc <= 1'b0;
            bad_addr     <= 32'h0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            pend_addr    <= pend_next;
            redirect     <= redirect_next;
            misalign_exc <= misalign;
            if (misalign) begin
                bad_addr <= target_addr;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_unit
//   Directed bench for pc_redirect_unit. Inputs change 1 ns after the rising
//   edge; outputs are sampled a further 1 ns later.
// -----------------------------------------------------------------------------
module tb_pc_redirect_unit;
    import pc_redirect_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic [3:0]  branch_op;
    logic        branch_taken;
    logic [31:0] target_addr;
    logic        stall;
    logic        imem_busy;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush_ifid;
    logic        flush_idex;
    logic        redirect;
    logic        misalign_exc;
    logic [31:0] bad_addr;
    pc_state_e   dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    pc_redirect_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .branch_op    (branch_op),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .stall        (stall),
        .imem_busy    (imem_busy),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .redirect     (redirect),
        .misalign_exc (misalign_exc),
        .bad_addr     (bad_addr),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_take(input logic [3:0] op, input logic [31:0] tgt);
        ex_valid     = 1'b1;
        branch_op    = op;
        branch_taken = 1'b1;
        target_addr  = tgt;
    endtask

    task automatic drive_idle();
        ex_valid     = 1'b0;
        branch_op    = 4'b0000;
        branch_taken = 1'b0;
        target_addr  = 32'h0;
    endtask

    initial begin
        reset_n   = 1'b0;
        stall     = 1'b0;
        imem_busy = 1'b0;
        // a take request while in reset must not raise any flush
        drive_take(BR_BEQ, 32'h0000_0040);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_flush_ifid", 32'(flush_ifid), 32'h0);
        chk("rst_flush_idex", 32'(flush_idex), 32'h0);
        chk("rst_redirect", 32'(redirect), 32'h0);
        chk("rst_misalign", 32'(misalign_exc), 32'h0);
        chk("rst_bad_addr", bad_addr, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
        drive_idle();
        repeat (2) step();
        reset_n = 1'b1;

        // 1: sequential fetch
        chk("seq_pc0", pc, 32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        while (exp_q.size() > 0) begin
            step();
            chk("seq_pc", pc, exp_q.pop_front());
        end

        // 2: BEQ taken, memory idle
        drive_take(BR_BEQ, 32'h0000_0040);
        #1;
        chk("beq_flush_ifid", 32'(flush_ifid), 32'h1);
        chk("beq_flush_idex", 32'(flush_idex), 32'h1);
        step();
        chk("beq_pc", pc, 32'h40);
        chk("beq_redirect", 32'(redirect), 32'h1);
        drive_idle();
        step();
        chk("beq_pc_next", pc, 32'h44);
        chk("beq_redirect_drop", 32'(redirect), 32'h0);

        // 3: JAL_JALR taken while memory busy for 3 cycles
        drive_take(BR_JAL_JALR, 32'h0000_0080);
        imem_busy = 1'b1;
        #1;
        chk("jal_c1_ifid", 32'(flush_ifid), 32'h1);
        chk("jal_c1_idex", 32'(flush_idex), 32'h1);
        step();
        drive_idle();
        #1;
        chk("jal_c2_pc", pc, 32'h44);
        chk("jal_c2_state", 32'(dbg_state), 32'(ST_PEND));
        chk("jal_c2_ifid", 32'(flush_ifid), 32'h1);
        chk("jal_c2_idex", 32'(flush_idex), 32'h0);
        step();
        chk("jal_c3_pc", pc, 32'h44);
        chk("jal_c3_ifid", 32'(flush_ifid), 32'h1);
        chk("jal_c3_idex", 32'(flush_idex), 32'h0);
        step();
        chk("jal_c4_pc", pc, 32'h44);
        imem_busy = 1'b0;
        step();
        chk("jal_drain_pc", pc, 32'h80);
        chk("jal_drain_redirect", 32'(redirect), 32'h1);
        chk("jal_drain_state", 32'(dbg_state), 32'(ST_RUN));
        step();
        chk("jal_after_pc", pc, 32'h84);

        // 4: misaligned BNE target traps
        drive_take(BR_BNE, 32'h0000_0042);
        step();
        drive_idle();
        #1;
        chk("mis_pc", pc, 32'h100);
        chk("mis_exc", 32'(misalign_exc), 32'h1);
        chk("mis_bad_addr", bad_addr, 32'h42);
        step();
        chk("mis_exc_drop", 32'(misalign_exc), 32'h0);
        chk("mis_bad_hold", bad_addr, 32'h42);
        chk("mis_pc_next", pc, 32'h104);

        // 5: take overrides stall; non-branch or bubble never takes
        stall = 1'b1;
        drive_take(BR_BGEU, 32'h0000_0200);
        step();
        drive_idle();
        chk("stall_take_pc", pc, 32'h200);
        step();
        chk("stall_hold_pc", pc, 32'h200);
        stall        = 1'b0;
        ex_valid     = 1'b1;
        branch_op    = 4'b0000;
        branch_taken = 1'b1;
        target_addr  = 32'h0000_0300;
        #1;
        chk("nonbr_flush_ifid", 32'(flush_ifid), 32'h0);
        chk("nonbr_flush_idex", 32'(flush_idex), 32'h0);
        step();
        chk("nonbr_pc", pc, 32'h204);
        drive_take(BR_BLT, 32'h0000_0300);
        ex_valid = 1'b0;
        #1;
        chk("bubble_flush_ifid", 32'(flush_ifid), 32'h0);
        step();
        chk("bubble_pc", pc, 32'h208);

        // 6: async reset in PEND drops the parked target
        drive_take(BR_BLTU, 32'h0000_0300);
        imem_busy = 1'b1;
        step();
        drive_idle();
        chk("pend_state", 32'(dbg_state), 32'(ST_PEND));
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_pc", pc, 32'h0);
        chk("areset_state", 32'(dbg_state), 32'(ST_RUN));
        chk("areset_flush", 32'(flush_ifid), 32'h0);
        step();
        reset_n   = 1'b1;
        imem_busy = 1'b0;
        step();
        chk("post_rst_pc", pc, 32'h4);
        chk("post_rst_redirect", 32'(redirect), 32'h0);

        // wrap of PC + 4
        drive_take(BR_JAL_JALR, 32'hFFFF_FFFC);
        step();
        drive_idle();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        step();
        chk("wrap_pc_next", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
